// File: rtl/pipelined_control_unit_pkg.sv
// Shared definitions for the pipelined control unit: RV32I opcodes,
// per-stage control bundles and the halt FSM state encoding.
package pipelined_control_unit_pkg;

    localparam logic [6:0] OPC_ARITH     = 7'b0110011;
    localparam logic [6:0] OPC_ARITH_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    // Register that carries the ECALL service code (a7).
    localparam int unsigned ECALL_ARG_REG = 17;

    // Bundles nest so each pipeline register only keeps the fields its
    // downstream stages still consume. halt is the ECALL halt marker.
    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic pc_to_reg;
        logic halt;
    } wb_ctrl_t;

    typedef struct packed {
        logic     mem_en;
        logic     mem_write;
        wb_ctrl_t ws;
    } mem_ctrl_t;

    typedef struct packed {
        logic      op2_imm;
        logic      branch;
        logic      jal;
        logic      jalr;
        mem_ctrl_t ms;
    } ctrl_t;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } pcu_state_t;

endpackage

// File: rtl/pipelined_control_unit_if.sv
// ID-side inputs and stage control outputs of the pipelined control unit.
// master: datapath / driver side.  slave: the control unit.
interface pipelined_control_unit_if #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned XLEN   = 32
);
    logic              id_valid;
    logic [6:0]        id_opcode;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic [REG_AW-1:0] id_rd;
    logic [XLEN-1:0]   ecall_arg;
    logic              ex_flush;

    logic              pc_write;
    logic              ifid_write;
    logic              ifid_flush;
    logic              ex_op2_imm;
    logic              ex_branch;
    logic              ex_jal;
    logic              ex_jalr;
    logic [REG_AW-1:0] ex_rd;
    logic [REG_AW-1:0] mem_rd;
    logic [REG_AW-1:0] wb_rd;
    logic              mem_enable;
    logic              mem_write;
    logic              mem_wb_enable;
    logic              wb_enable;
    logic              wb_mem_to_reg;
    logic              wb_pc_to_reg;
    logic              halted;

    modport master (
        output id_valid, id_opcode, id_rs1, id_rs2, id_rd, ecall_arg, ex_flush,
        input  pc_write, ifid_write, ifid_flush, ex_op2_imm, ex_branch, ex_jal,
               ex_jalr, ex_rd, mem_rd, wb_rd, mem_enable, mem_write,
               mem_wb_enable, wb_enable, wb_mem_to_reg, wb_pc_to_reg, halted
    );

    modport slave (
        input  id_valid, id_opcode, id_rs1, id_rs2, id_rd, ecall_arg, ex_flush,
        output pc_write, ifid_write, ifid_flush, ex_op2_imm, ex_branch, ex_jal,
               ex_jalr, ex_rd, mem_rd, wb_rd, mem_enable, mem_write,
               mem_wb_enable, wb_enable, wb_mem_to_reg, wb_pc_to_reg, halted
    );
endinterface

// File: rtl/pipelined_control_unit_control_decoder.sv
// Combinational ID-stage decoder: opcode -> control bundle.
// Ports: valid/opcode/rd in; ctrl bundle, ctrl_rd (rd kept only when the
// instruction writes back), use_rs1/use_rs2 and is_ecall out.
module control_decoder
    import pipelined_control_unit_pkg::*;
#(
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned SUPPORT_BR = 1
) (
    input  logic              valid,
    input  logic [6:0]        opcode,
    input  logic [REG_AW-1:0] rd,
    output ctrl_t             ctrl,
    output logic [REG_AW-1:0] ctrl_rd,
    output logic              use_rs1,
    output logic              use_rs2,
    output logic              is_ecall
);

    always_comb begin
        ctrl     = '0;
        ctrl_rd  = '0;
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        is_ecall = 1'b0;
        if (valid) begin
            case (opcode)
                OPC_ARITH: begin
                    ctrl.ms.ws.reg_write = 1'b1;
                    use_rs1 = 1'b1;
                    use_rs2 = 1'b1;
                end
                OPC_ARITH_IMM: begin
                    ctrl.ms.ws.reg_write = 1'b1;
                    ctrl.op2_imm = 1'b1;
                    use_rs1 = 1'b1;
                end
                OPC_LOAD: begin
                    ctrl.ms.ws.reg_write  = 1'b1;
                    ctrl.ms.mem_en        = 1'b1;
                    ctrl.op2_imm          = 1'b1;
                    ctrl.ms.ws.mem_to_reg = 1'b1;
                    use_rs1 = 1'b1;
                end
                OPC_STORE: begin
                    ctrl.ms.mem_en    = 1'b1;
                    ctrl.ms.mem_write = 1'b1;
                    ctrl.op2_imm      = 1'b1;
                    use_rs1 = 1'b1;
                    use_rs2 = 1'b1;
                end
                OPC_BRANCH: begin
                    if (SUPPORT_BR != 0) begin
                        ctrl.branch = 1'b1;
                        use_rs1 = 1'b1;
                        use_rs2 = 1'b1;
                    end
                end
                OPC_JAL: begin
                    if (SUPPORT_BR != 0) begin
                        ctrl.jal             = 1'b1;
                        ctrl.ms.ws.reg_write = 1'b1;
                        ctrl.ms.ws.pc_to_reg = 1'b1;
                    end
                end
                OPC_JALR: begin
                    if (SUPPORT_BR != 0) begin
                        ctrl.jalr            = 1'b1;
                        ctrl.ms.ws.reg_write = 1'b1;
                        ctrl.ms.ws.pc_to_reg = 1'b1;
                        ctrl.op2_imm         = 1'b1;
                        use_rs1 = 1'b1;
                    end
                end
                OPC_SYSTEM: is_ecall = 1'b1;
                default: ;
            endcase
        end
        // Writes to x0 are dropped; rd is only meaningful alongside a write,
        // so it is zeroed otherwise to keep forwarding/hazard compares clean.
        if (rd == '0) ctrl.ms.ws.reg_write = 1'b0;
        if (ctrl.ms.ws.reg_write) ctrl_rd = rd;
    end

endmodule

// File: rtl/pipelined_control_unit.sv
// Control unit for the 5-stage RV32I core. Decodes the ID instruction,
// carries the control bundle through ID/EX, EX/MEM and MEM/WB, and applies
// load-use / ECALL stalls, EX branch flushes and the ECALL halt drain.
// Ports: clk, reset_n (async active-low), bus (pipelined_control_unit_if.slave)
// carrying ID fields, ecall_arg, ex_flush in and all stage controls out.
module pipelined_control_unit
    import pipelined_control_unit_pkg::*;
#(
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned XLEN       = 32,
    parameter int unsigned HALT_CODE  = 10,
    parameter int unsigned SUPPORT_BR = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    pipelined_control_unit_if.slave  bus
);

    ctrl_t             id_ctrl, id_next, ex_ctrl;
    mem_ctrl_t         mem_ctrl;
    wb_ctrl_t          wb_ctrl;
    logic [REG_AW-1:0] id_rd_dec, ex_rd_q, mem_rd_q, wb_rd_q;
    logic              use_rs1, use_rs2, id_is_ecall;
    logic              load_use, ecall_stall, stall, idex_bubble, halt_accept, fetch_en;
    pcu_state_t        state;
    logic              halted_q;

    control_decoder #(
        .REG_AW     (REG_AW),
        .SUPPORT_BR (SUPPORT_BR)
    ) u_decoder (
        .valid    (bus.id_valid),
        .opcode   (bus.id_opcode),
        .rd       (bus.id_rd),
        .ctrl     (id_ctrl),
        .ctrl_rd  (id_rd_dec),
        .use_rs1  (use_rs1),
        .use_rs2  (use_rs2),
        .is_ecall (id_is_ecall)
    );

    always_comb begin
        load_use = ex_ctrl.ms.mem_en && !ex_ctrl.ms.mem_write && (ex_rd_q != '0) &&
                   ((use_rs1 && bus.id_rs1 == ex_rd_q) || (use_rs2 && bus.id_rs2 == ex_rd_q));
        // x17 not yet available to the datapath's MEM/WB forward path.
        ecall_stall = id_is_ecall &&
                      ((ex_ctrl.ms.ws.reg_write && ex_rd_q == REG_AW'(ECALL_ARG_REG)) ||
                       (mem_ctrl.mem_en && !mem_ctrl.mem_write &&
                        mem_rd_q == REG_AW'(ECALL_ARG_REG)));
        stall       = load_use || ecall_stall;
        idex_bubble = (state != ST_RUN) || bus.ex_flush || stall;
        halt_accept = !idex_bubble && id_is_ecall && (bus.ecall_arg == XLEN'(HALT_CODE));
        // Flush overrides stall: the stalled instruction is squashed anyway.
        fetch_en    = (state == ST_RUN) && (bus.ex_flush || !stall);
        id_next     = id_ctrl;
        id_next.ms.ws.halt = halt_accept;
        if (idex_bubble) id_next = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_ctrl  <= '0;
            mem_ctrl <= '0;
            wb_ctrl  <= '0;
            ex_rd_q  <= '0;
            mem_rd_q <= '0;
            wb_rd_q  <= '0;
            state    <= ST_RUN;
            halted_q <= 1'b0;
        end else begin
            ex_ctrl  <= id_next;
            ex_rd_q  <= idex_bubble ? '0 : id_rd_dec;
            mem_ctrl <= ex_ctrl.ms;
            mem_rd_q <= ex_rd_q;
            wb_ctrl  <= mem_ctrl.ws;
            wb_rd_q  <= mem_rd_q;
            case (state)
                ST_RUN:    if (halt_accept) state <= ST_DRAIN;
                ST_DRAIN: begin
                    if (wb_ctrl.halt) begin
                        state    <= ST_HALTED;
                        halted_q <= 1'b1;
                    end
                end
                ST_HALTED: ;
                default:   state <= ST_RUN;
            endcase
        end
    end

    assign bus.pc_write      = fetch_en;
    assign bus.ifid_write    = fetch_en;
    assign bus.ifid_flush    = bus.ex_flush;
    assign bus.ex_op2_imm    = ex_ctrl.op2_imm;
    assign bus.ex_branch     = ex_ctrl.branch;
    assign bus.ex_jal        = ex_ctrl.jal;
    assign bus.ex_jalr       = ex_ctrl.jalr;
    assign bus.ex_rd         = ex_rd_q;
    assign bus.mem_rd        = mem_rd_q;
    assign bus.wb_rd         = wb_rd_q;
    assign bus.mem_enable    = mem_ctrl.mem_en;
    assign bus.mem_write     = mem_ctrl.mem_write;
    assign bus.mem_wb_enable = mem_ctrl.ws.reg_write;
    assign bus.wb_enable     = wb_ctrl.reg_write;
    assign bus.wb_mem_to_reg = wb_ctrl.mem_to_reg;
    assign bus.wb_pc_to_reg  = wb_ctrl.pc_to_reg;
    assign bus.halted        = halted_q;

endmodule
